// File: rtl/password_stream_tx.sv
// Buffered ASCII string transmitter with a valid/ready handshake toward a checker.
// Optional NUL terminator after the last character: define TX_TERMINATOR_EN.
module password_stream_tx #(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [7:0]                 wr_data,
    input  logic                       clear,
    input  logic                       start,
    input  logic                       ready,
    output logic                       en_out,
    output logic [7:0]                 data_out,
    output logic                       busy,
    output logic                       done,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        TERM = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] count_n;
    logic [IW-1:0] rd_idx, rd_idx_n, rd_idx_inc;
    logic          en_n;
    logic [7:0]    data_n;
    logic          wr_fire;
    logic          last_char;
    logic [7:0]    mem [DEPTH];

    assign full       = (count == CW'(DEPTH));
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign rd_idx_inc = rd_idx + 1'b1;
    assign last_char  = ({1'b0, rd_idx} == (count - 1'b1));

    // Storage has no reset; it is only read below the loaded length.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[count[IW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            count    <= '0;
            rd_idx   <= '0;
            en_out   <= 1'b0;
            data_out <= 8'h00;
        end else begin
            state    <= state_n;
            count    <= count_n;
            rd_idx   <= rd_idx_n;
            en_out   <= en_n;
            data_out <= data_n;
        end
    end

    // In IDLE, clear beats start, which beats a write.
    always_comb begin
        state_n  = state;
        count_n  = count;
        rd_idx_n = rd_idx;
        en_n     = en_out;
        data_n   = data_out;
        wr_fire  = 1'b0;
        case (state)
            IDLE: begin
                en_n   = 1'b0;
                data_n = 8'h00;
                if (clear) begin
                    count_n = '0;
                end else if (start) begin
                    rd_idx_n = '0;
                    if (count != '0) begin
                        state_n = SEND;
                        en_n    = 1'b1;
                        data_n  = mem[0];
                    end else begin
                        state_n = DONE;
                    end
                end else if (wr_en && !full) begin
                    wr_fire = 1'b1;
                    count_n = count + 1'b1;
                end
            end
            SEND: begin
                if (ready) begin
                    if (last_char) begin
`ifdef TX_TERMINATOR_EN
                        state_n = TERM;
                        en_n    = 1'b1;
                        data_n  = 8'h00;
`else
                        state_n = DONE;
                        en_n    = 1'b0;
                        data_n  = 8'h00;
`endif
                    end else begin
                        rd_idx_n = rd_idx_inc;
                        data_n   = mem[rd_idx_inc];
                    end
                end
            end
            TERM: begin
                if (ready) begin
                    state_n = DONE;
                    en_n    = 1'b0;
                    data_n  = 8'h00;
                end
            end
            DONE: begin
                state_n  = IDLE;
                rd_idx_n = '0;
                en_n     = 1'b0;
                data_n   = 8'h00;
            end
            default: begin
                state_n = IDLE;
                en_n    = 1'b0;
                data_n  = 8'h00;
            end
        endcase
    end

endmodule

// File: tb/tb_password_stream_tx.sv
// Directed bench for password_stream_tx: loading, handshake stalls, overflow, empty start, reset abort.
// Expected streams include the NUL terminator when TX_TERMINATOR_EN is defined.
module tb_password_stream_tx;

    localparam int DEPTH = 16;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       clear;
    logic       start;
    logic       ready;
    logic       en_out;
    logic [7:0] data_out;
    logic       busy;
    logic       done;
    logic       full;
    logic [4:0] count;

    int vectorCount = 0;
    int missCount   = 0;

    password_stream_tx #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .clear    (clear),
        .start    (start),
        .ready    (ready),
        .en_out   (en_out),
        .data_out (data_out),
        .busy     (busy),
        .done     (done),
        .full     (full),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input string s);
        for (int i = 0; i < s.len(); i++) begin
            wr_en   = 1'b1;
            wr_data = s[i];
            step();
        end
        wr_en   = 1'b0;
        wr_data = 8'h00;
    endtask

    task automatic checkIdleZero(input string tag);
        checkOutput({tag, "_en"},   32'(en_out),   32'd0);
        checkOutput({tag, "_data"}, 32'(data_out), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy),     32'd0);
        checkOutput({tag, "_done"}, 32'(done),     32'd0);
    endtask

    // Starts a transmission and follows the expected byte stream; ready is low on SEND cycles stallFirst..stallLast.
    task automatic transmit(input string tag, input string s, input int stallFirst, input int stallLast);
        int         seqLen;
        int         idx;
        int         cyc;
        logic [7:0] expByte;
        seqLen = s.len();
`ifdef TX_TERMINATOR_EN
        seqLen = seqLen + 1;
`endif
        ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < seqLen && cyc < 200) begin
            cyc++;
            ready   = !(cyc >= stallFirst && cyc <= stallLast);
            expByte = (idx < s.len()) ? s[idx] : 8'h00;
            checkOutput({tag, "_en"},   32'(en_out),   32'd1);
            checkOutput({tag, "_data"}, 32'(data_out), 32'(expByte));
            checkOutput({tag, "_busy"}, 32'(busy),     32'd1);
            checkOutput({tag, "_done"}, 32'(done),     32'd0);
            if (ready) idx++;
            step();
        end
        ready = 1'b1;
        checkOutput({tag, "_donePulse"}, 32'(done),     32'd1);
        checkOutput({tag, "_doneEn"},    32'(en_out),   32'd0);
        checkOutput({tag, "_doneData"},  32'(data_out), 32'd0);
        checkOutput({tag, "_doneBusy"},  32'(busy),     32'd1);
        step();
        checkIdleZero({tag, "_after"});
        checkOutput({tag, "_count"}, 32'(count), 32'(s.len()));
    endtask

    initial begin
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        clear   = 1'b0;
        start   = 1'b0;
        ready   = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        checkIdleZero("rst");
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_full",  32'(full),  32'd0);
        step();
        step();
        reset = 1'b1;
        step();

        $display("[TB] abcdef back-to-back");
        applyStimulus("abcdef");
        checkOutput("load6_count", 32'(count), 32'd6);
        transmit("abc", "abcdef", 0, -1);

        $display("[TB] retransmit after done");
        transmit("again", "abcdef", 0, -1);

        $display("[TB] andre with stall");
        clear = 1'b1;
        step();
        clear = 1'b0;
        checkOutput("clr_count", 32'(count), 32'd0);
        applyStimulus("andre");
        transmit("andre", "andre", 2, 3);

        $display("[TB] overflow");
        clear = 1'b1;
        step();
        clear = 1'b0;
        applyStimulus("ABCDEFGHIJKLMNOPQ");
        checkOutput("ovf_count", 32'(count), 32'd16);
        checkOutput("ovf_full",  32'(full),  32'd1);
        transmit("ovf", "ABCDEFGHIJKLMNOP", 0, -1);

        $display("[TB] priority and ignored inputs");
        clear = 1'b1;
        step();
        clear = 1'b0;
        applyStimulus("xy");
        checkOutput("xy_full", 32'(full), 32'd0);
        start   = 1'b1;
        clear   = 1'b1;
        wr_en   = 1'b1;
        wr_data = "q";
        step();
        clear = 1'b0;
        wr_en = 1'b0;
        start = 1'b0;
        checkOutput("pri_clrCount", 32'(count), 32'd0);
        checkOutput("pri_clrBusy",  32'(busy),  32'd0);
        applyStimulus("xy");
        ready   = 1'b1;
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_data = "z";
        step();
        clear = 1'b1;
        checkOutput("ign_x", 32'(data_out), 32'("x"));
        step();
        checkOutput("ign_y", 32'(data_out), 32'("y"));
        step();
`ifdef TX_TERMINATOR_EN
        checkOutput("ign_termEn",   32'(en_out),   32'd1);
        checkOutput("ign_termData", 32'(data_out), 32'd0);
        step();
`endif
        checkOutput("ign_done", 32'(done), 32'd1);
        start = 1'b0;
        wr_en = 1'b0;
        clear = 1'b0;
        step();
        checkOutput("ign_count", 32'(count), 32'd2);
        checkOutput("ign_busy",  32'(busy),  32'd0);
        transmit("ign_re", "xy", 0, -1);

        $display("[TB] empty start");
        clear = 1'b1;
        step();
        clear = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        checkOutput("empty_done", 32'(done),   32'd1);
        checkOutput("empty_busy", 32'(busy),   32'd1);
        checkOutput("empty_en",   32'(en_out), 32'd0);
        step();
        checkIdleZero("empty_after");

        $display("[TB] reset mid-send");
        applyStimulus("abcdef");
        ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        checkOutput("abort_c", 32'(data_out), 32'("c"));
        reset = 1'b0;
        #1;
        checkIdleZero("abort");
        checkOutput("abort_count", 32'(count), 32'd0);
        step();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checkOutput("abort_noDone", 32'(done), 32'd0);
            checkOutput("abort_noEn",   32'(en_out), 32'd0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
